contador_bcd_9999: RTL

Four-digit BCD up/down counter, 0000–9999, with a programmable prescaler, enable and synchronous clear. It sits directly upstream of the four 7-segment digit decoders. Each 4-bit digit output feeds one decoder input, units first. Because every digit stays in 0–9, the decoders' A–F glyphs never appear on the display.

---
 rtl/contador_bcd_9999.sv | 97 +++++++++
 1 files changed

// File: rtl/contador_bcd_9999.sv
// contador_bcd_9999 -- four-digit BCD up/down counter (0000..9999) with a
// programmable prescaler, count enable and synchronous clear.
//
// Parameters:
//   DIV    CLK cycles per count step (1 .. 2**DIV_W-1)
//   DIV_W  prescaler width
// Ports:
//   CLK    system clock, rising edge
//   RST    asynchronous active-high reset
//   EN     count enable; low freezes prescaler and digits
//   UP     direction, 1 = increment, 0 = decrement (sampled on steps)
//   CLR    synchronous clear of digits and prescaler (acts even with EN=0)
//   Z1..Z4 units..thousands BCD digits
//   TICK   one-cycle pulse after each count step
//   WRAP   one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
module contador_bcd_9999 #(
    parameter int unsigned DIV   = 50_000_000,
    parameter int unsigned DIV_W = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       UP,
    input  logic       CLR,
    output logic [3:0] Z1,
    output logic [3:0] Z2,
    output logic [3:0] Z3,
    output logic [3:0] Z4,
    output logic       TICK,
    output logic       WRAP
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] presc;
    logic [3:0]       digit     [4];
    logic [3:0]       digit_nxt [4];
    logic             carry;
    logic             step;

    assign step = EN && (presc == PRESC_LAST);

    // Carry/borrow chain across all four digits, resolved in one cycle.
    // A carry surviving past the thousands digit is exactly the wrap case.
    always_comb begin
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            digit_nxt[i] = digit[i];
            if (carry) begin
                if (UP) begin
                    if (digit[i] == 4'd9) begin
                        digit_nxt[i] = 4'd0;
                    end else begin
                        digit_nxt[i] = digit[i] + 4'd1;
                        carry        = 1'b0;
                    end
                end else begin
                    if (digit[i] == 4'd0) begin
                        digit_nxt[i] = 4'd9;
                    end else begin
                        digit_nxt[i] = digit[i] - 4'd1;
                        carry        = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            for (int unsigned i = 0; i < 4; i++) digit[i] <= '0;
            TICK  <= 1'b0;
            WRAP  <= 1'b0;
        end else if (CLR) begin
            presc <= '0;
            for (int unsigned i = 0; i < 4; i++) digit[i] <= '0;
            TICK  <= 1'b0;
            WRAP  <= 1'b0;
        end else if (step) begin
            presc <= '0;
            for (int unsigned i = 0; i < 4; i++) digit[i] <= digit_nxt[i];
            TICK  <= 1'b1;
            WRAP  <= carry;
        end else begin
            if (EN) presc <= presc + DIV_W'(1);
            TICK <= 1'b0;
            WRAP <= 1'b0;
        end
    end

    assign Z1 = digit[0];
    assign Z2 = digit[1];
    assign Z3 = digit[2];
    assign Z4 = digit[3];

endmodule
